// File: rtl/game_director.sv
// Pacman game sequencer: lives, BCD score, freeze level and respawn pulses.
// Optional best-score tracking is built when GAME_DIRECTOR_HISCORE_EN is defined.
module game_director #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned DEATH_FRAMES = 120,
  parameter int unsigned PELLET_PTS   = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        isDefeated,
  input  logic        hasMoved,
  input  logic        pellet_eaten,
  output logic [2:0]  state,
  output logic [2:0]  lives,
  output logic [15:0] score,
  output logic [15:0] hiscore,
  output logic        freeze,
  output logic        respawn,
  output logic        game_over
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StPlay     = 3'd1;
  localparam logic [2:0] StDying    = 3'd2;
  localparam logic [2:0] StRespawn  = 3'd3;
  localparam logic [2:0] StGameOver = 3'd4;

  localparam logic [3:0] PtsOnes   = 4'(PELLET_PTS % 10);
  localparam logic [3:0] PtsTens   = 4'((PELLET_PTS / 10) % 10);
  localparam logic [7:0] LastFrame = 8'(DEATH_FRAMES - 1);
  localparam logic [2:0] LivesInit = 3'(LIVES);

  logic [2:0]  fs_q;
  logic        start_q;
  logic        tick, start_edge;
  logic [2:0]  state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        respawn_q, respawn_d;
  logic        freeze_q, game_over_q;

  // Per-digit BCD add; a carry out of the top digit saturates the score.
  function automatic logic [15:0] bcd_add(input logic [15:0] a);
    logic [15:0] sum;
    logic [4:0]  d;
    logic [3:0]  addend;
    logic        carry;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addend = (i == 0) ? PtsOnes : ((i == 1) ? PtsTens : 4'd0);
      d = {1'b0, a[i*4 +: 4]} + {1'b0, addend} + {4'd0, carry};
      if (d > 5'd9) begin
        d     = d - 5'd10;
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      sum[i*4 +: 4] = d[3:0];
    end
    return carry ? 16'h9999 : sum;
  endfunction

  assign tick       = fs_q[1] & ~fs_q[2];
  assign start_edge = start & ~start_q;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    cnt_d     = cnt_q;
    respawn_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d   = StPlay;
          lives_d   = LivesInit;
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      StPlay: begin
        if (pellet_eaten) score_d = bcd_add(score_q);
        if (isDefeated && hasMoved) begin
          state_d = StDying;
          lives_d = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
          cnt_d   = '0;
        end
      end
      StDying: begin
        if (tick) begin
          if (cnt_q == LastFrame) begin
            state_d   = (lives_q != 3'd0) ? StRespawn : StGameOver;
            respawn_d = (lives_q != 3'd0);
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StRespawn: begin
        if (tick && !isDefeated) state_d = StPlay;
      end
      StGameOver: begin
        if (start_edge) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_q        <= '0;
      start_q     <= 1'b0;
      state_q     <= StIdle;
      lives_q     <= '0;
      score_q     <= '0;
      cnt_q       <= '0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      fs_q        <= {fs_q[1:0], frame_clk};
      start_q     <= start;
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      cnt_q       <= cnt_d;
      respawn_q   <= respawn_d;
      freeze_q    <= (state_d != StPlay);
      game_over_q <= (state_d == StGameOver);
    end
  end

`ifdef GAME_DIRECTOR_HISCORE_EN
  logic [15:0] hiscore_q;

  // BCD digits order the same way as binary, so a plain compare suffices.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hiscore_q <= '0;
    end else if (state_q == StGameOver && score_q > hiscore_q) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = 16'h0000;
`endif

`ifndef SYNTHESIS
  lives_no_underflow: assert property (@(posedge Clk) disable iff (!Reset_n)
    !(state_q == StPlay && isDefeated && hasMoved && lives_q == 3'd0));
`endif

  assign state     = state_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_director.sv
// Bench for game_director: directed table, multi-cycle game sequences and a
// randomized run, all checked against a decimal-arithmetic game model.
module tb_game_director;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic        start = 1'b0;
  logic        isDefeated = 1'b0;
  logic        hasMoved = 1'b0;
  logic        pellet_eaten = 1'b0;
  logic [2:0]  state;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [15:0] hiscore;
  logic        freeze;
  logic        respawn;
  logic        game_over;

  always #5 Clk = ~Clk;

  game_director dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .start        (start),
    .isDefeated   (isDefeated),
    .hasMoved     (hasMoved),
    .pellet_eaten (pellet_eaten),
    .state        (state),
    .lives        (lives),
    .score        (score),
    .hiscore      (hiscore),
    .freeze       (freeze),
    .respawn      (respawn),
    .game_over    (game_over)
  );

`ifdef GAME_DIRECTOR_HISCORE_EN
  localparam bit HsEn = 1'b1;
`else
  localparam bit HsEn = 1'b0;
`endif

  localparam int Lives = 3;
  localparam int DeathFrames = 120;
  localparam int Pts = 10;
  localparam logic [40:0] RstVal = {3'd0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};

  int vectors = 0;
  int miscompares = 0;
  int resp_cnt = 0;

  // Model: states 0 idle, 1 play, 2 dying, 3 respawn, 4 game over; score in decimal.
  int m_state, m_lives, m_score, m_hiscore, m_dticks;
  bit m_resp, m_prev_start, h1, h2, h3;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [40:0] pack_dut();
    return {state, lives, score, hiscore, freeze, respawn, game_over};
  endfunction

  function automatic logic [40:0] pack_model();
    return {3'(m_state), 3'(m_lives), to_bcd(m_score), to_bcd(m_hiscore),
            m_state != 1, m_resp, m_state == 4};
  endfunction

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_hiscore = 0; m_dticks = 0;
    m_resp = 0; m_prev_start = 0; h1 = 0; h2 = 0; h3 = 0;
  endtask

  // One clock edge of the game rules; a frame edge is seen two edges after sampling.
  task automatic model_step(input bit st, input bit isd, input bit hm, input bit pel,
                            input bit fr);
    bit tick, se;
    tick = h2 && !h3;
    h3 = h2; h2 = h1; h1 = fr;
    se = st && !m_prev_start;
    m_prev_start = st;
    m_resp = 0;
    case (m_state)
      0: if (se) begin m_state = 1; m_lives = Lives; m_score = 0; m_resp = 1; end
      1: begin
        if (pel) m_score = (m_score + Pts > 9999) ? 9999 : m_score + Pts;
        if (isd && hm) begin m_state = 2; m_lives--; m_dticks = 0; end
      end
      2: if (tick) begin
        m_dticks++;
        if (m_dticks == DeathFrames) begin
          if (m_lives > 0) begin m_state = 3; m_resp = 1; end
          else m_state = 4;
        end
      end
      3: if (tick && !isd) m_state = 1;
      4: begin
        if (HsEn && m_score > m_hiscore) m_hiscore = m_score;
        if (se) m_state = 0;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit st, input bit isd, input bit hm, input bit pel, input bit fr);
    @(negedge Clk);
    start = st; isDefeated = isd; hasMoved = hm; pellet_eaten = pel; frame_clk = fr;
    model_step(st, isd, hm, pel, fr);
    @(posedge Clk);
    #1;
    check("cycle vs model", pack_dut(), pack_model());
    if (respawn) resp_cnt++;
  endtask

  task automatic tickp(input bit isd, input bit hm);
    cyc(0, isd, hm, 0, 1);
    cyc(0, isd, hm, 0, 1);
    cyc(0, isd, hm, 0, 0);
    cyc(0, isd, hm, 0, 0);
  endtask

  typedef struct {
    bit          st, isd, hm, pel;
    logic [2:0]  e_state;
    logic [2:0]  e_lives;
    logic [15:0] e_score;
    bit          e_freeze, e_resp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{0, 0, 0, 0, 3'd0, 3'd0, 16'h0000, 1, 0};
    tbl[1] = '{1, 0, 0, 0, 3'd1, 3'd3, 16'h0000, 0, 1};
    tbl[2] = '{1, 0, 0, 1, 3'd1, 3'd3, 16'h0010, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 3'd1, 3'd3, 16'h0020, 0, 0};
    tbl[4] = '{0, 1, 0, 0, 3'd1, 3'd3, 16'h0020, 0, 0};
    tbl[5] = '{1, 0, 0, 0, 3'd1, 3'd3, 16'h0020, 0, 0};
    tbl[6] = '{0, 1, 1, 1, 3'd2, 3'd2, 16'h0030, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 3'd2, 3'd2, 16'h0030, 1, 0};
    tbl[8] = '{1, 0, 0, 0, 3'd2, 3'd2, 16'h0030, 1, 0};

    model_reset();
    repeat (3) @(negedge Clk);
    check("reset values", pack_dut(), RstVal);
    Reset_n = 1'b1;

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].isd, tbl[i].hm, tbl[i].pel, 0);
      check($sformatf("table row %0d", i), {state, lives, score, freeze, respawn},
            {tbl[i].e_state, tbl[i].e_lives, tbl[i].e_score, tbl[i].e_freeze, tbl[i].e_resp});
    end

    // Death 1: 119 ticks keep DYING, the 120th enters RESPAWN with one pulse.
    resp_cnt = 0;
    for (int i = 0; i < 119; i++) tickp(1, 0);
    check("dying after 119 ticks", state, 3'd2);
    tickp(1, 0);
    check("respawn after 120 ticks", state, 3'd3);
    check("respawn pulse count", resp_cnt, 1);
    tickp(1, 0);
    check("respawn held while defeated", state, 3'd3);
    tickp(0, 0);
    check("respawn to play", {state, freeze}, {3'd1, 1'b0});

    // Death 2 with a tick landing on the death edge: that tick must not count.
    cyc(0, 0, 1, 0, 1);
    cyc(0, 0, 1, 0, 1);
    cyc(0, 1, 1, 0, 0);
    check("death 2 state/lives", {state, lives}, {3'd2, 3'd1});
    for (int i = 0; i < 119; i++) tickp(0, 0);
    check("death 2 ignores edge tick", state, 3'd2);
    tickp(0, 0);
    tickp(0, 0);
    check("death 2 back to play", state, 3'd1);

    // Death 3 with a pellet on the death edge, then GAME_OVER.
    cyc(0, 1, 1, 1, 0);
    check("death 3 pellet scored", {state, lives, score}, {3'd2, 3'd0, 16'h0040});
    for (int i = 0; i < 120; i++) tickp(0, 0);
    check("game over", {state, lives, game_over, freeze}, {3'd4, 3'd0, 1'b1, 1'b1});
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("hiscore at game over", hiscore, HsEn ? 16'h0040 : 16'h0000);
    cyc(1, 0, 0, 0, 0);
    check("idle score held", {state, score}, {3'd0, 16'h0040});
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("restart clears score", {state, lives, score}, {3'd1, 3'd3, 16'h0000});
    check("hiscore retained", hiscore, HsEn ? 16'h0040 : 16'h0000);

    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 0);
    check("12 pellets", score, 16'h0120);
    for (int i = 0; i < 1000; i++) cyc(0, 0, 0, 1, 0);
    check("score saturates", score, 16'h9999);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    check("score stays saturated", score, 16'h9999);

    // Asynchronous reset in the middle of DYING, frame_clk toggling meanwhile.
    cyc(0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) tickp(0, 0);
    check("dying before reset", state, 3'd2);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    model_reset();
    #1 check("async reset mid-dying", pack_dut(), RstVal);
    for (int i = 0; i < 8; i++) begin
      #3 frame_clk = ~frame_clk;
    end
    @(negedge Clk);
    frame_clk = 1'b0;
    start = 1'b0;
    check("held in reset", pack_dut(), RstVal);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("idle after reset", pack_dut(), RstVal);

    // Randomized play against the model.
    begin
      bit fr;
      int left;
      fr = 0;
      left = 3;
      for (int i = 0; i < 6000; i++) begin
        if (--left == 0) begin
          fr = ~fr;
          left = int'($urandom_range(2, 5));
        end
        cyc(($urandom % 16) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
            ($urandom % 3) == 0, fr);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
